rmii_frame_rx: RTL
==================

RMII_FRAME_RX -- requirements
Module: rmii_frame_rx

Interface
REQ-001 Parameter MIN_LEN, default 64: minimum legal frame length in bytes, counted from destination address through FCS inclusive.
REQ-002 Parameter MAX_LEN, default 1518: maximum legal frame length in bytes, same counting rule as MIN_LEN.
REQ-003 clk  input  1: 50 MHz RMII reference clock; the only clock.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 crs_dv  input  1: RMII carrier-sense/data-valid, sampled on rising clk.
REQ-006 rx_er  input  1: RMII receive error.
REQ-007 rx_d  input  2: RMII receive dibit, bit 0 earliest on wire.
REQ-008 data_o  output  8: received byte; valid only while valid_o=1.
REQ-009 valid_o  output  1: one-cycle strobe per received byte.
REQ-010 sof_o  output  1: high with valid_o on the first byte after the SFD.
REQ-011 eof_o  output  1: one-cycle end-of-frame strobe, never coincident with valid_o.
REQ-012 fcs_ok_o  output  1: FCS check result; qualified by eof_o.
REQ-013 err_o  output  1: frame error flag; qualified by eof_o.
REQ-014 frame_len_o  output  11: byte count of the ended frame; qualified by eof_o.

Function
REQ-015 States SHALL be IDLE, PREAMBLE, DATA and DROP.
REQ-016 IDLE: crs_dv=0 or rx_d=00 -> stay; crs_dv=1 with rx_d=01 -> PREAMBLE with preamble count 1; crs_dv=1 with rx_d=10 or 11 -> DROP.
REQ-017 PREAMBLE, rx_d=01: increment the preamble count, saturating at 15.
REQ-018 PREAMBLE, rx_d=11 with preamble count >=4: SFD accepted; go to DATA with dibit phase 0, byte count 0 and CRC register 0xFFFFFFFF.
REQ-019 PREAMBLE, any other case -> DROP, with no eof_o: rx_d=11 with count <4, rx_d=00 or 10, crs_dv=0, or rx_er=1.
REQ-020 DATA assembly: each cycle with crs_dv=1, shift register <= {rx_d, shift[7:2]} and the dibit phase increments modulo 4.
REQ-021 DATA byte completion: on phase 3, the completed byte SHALL appear on data_o with valid_o=1 on the next cycle (latency 1 clk from the 4th dibit sample).
REQ-022 Byte count SHALL increment per completed byte, saturating at 2047.
REQ-023 CRC-32 SHALL be updated per completed byte: reflected polynomial 0xEDB88320, LSB first, covering all bytes including the FCS.
REQ-024 FCS pass condition: CRC register equals 0xDEBB20E3 at end of frame.
REQ-025 All bytes including the 4 FCS bytes SHALL be emitted on data_o.
REQ-026 rx_er=1 in DATA SHALL set an internal error flag; byte emission continues.
REQ-027 When the byte count would exceed MAX_LEN: set the error flag, suppress further valid_o, go to DROP-with-report; byte count keeps counting.
REQ-028 End of frame: crs_dv=0 in DATA (or in DROP-with-report) -> eof_o=1 on the next cycle, then IDLE.
REQ-029 At eof_o, frame_len_o SHALL equal the byte count.
REQ-030 At eof_o, err_o=1 if any of: error flag set, dibit phase !=0 at crs_dv fall (partial byte discarded), byte count <MIN_LEN, or byte count >MAX_LEN.
REQ-031 At eof_o, fcs_ok_o=1 only if the CRC pass condition holds and the phase was 0; fcs_ok_o is independent of length errors.
REQ-032 DROP (non-report): wait for crs_dv=0, then IDLE; no outputs asserted.
REQ-033 eof_o, valid_o and sof_o SHALL be zero in every cycle not stated above; data_o holds its last value.

Reset
REQ-034 rst_n=0 SHALL asynchronously force all outputs to 0, all counters to 0, CRC to 0xFFFFFFFF and the state to DROP.
REQ-035 After reset, reception SHALL begin only after crs_dv is seen 0 for at least one cycle (no partial-frame capture when reset releases mid-frame).

Verification
REQ-036 Bench SHALL drive 7x 0x55 + 0xD5 + 60 payload bytes (first 0xA5, dibits 01,01,10,10) + correct FCS -> 64 valid_o strobes, first data_o=0xA5 with sof_o=1, then eof_o with fcs_ok_o=1, err_o=0, frame_len_o=64.
REQ-037 Bench SHALL run the same frame with one payload bit flipped -> 64 bytes emitted; eof_o with fcs_ok_o=0, err_o=0.
REQ-038 Bench SHALL send a preamble of only 3 dibits 01 then 11 -> no valid_o and no eof_o; the next good frame is received normally.
REQ-039 Bench SHALL drop crs_dv after 2 dibits of byte 65 -> 64 bytes emitted; eof_o with err_o=1, fcs_ok_o=0, frame_len_o=64.
REQ-040 Bench SHALL send a 1530-byte frame -> exactly 1518 valid_o strobes; eof_o with err_o=1, frame_len_o=1530.
REQ-041 Bench SHALL assert rst_n=0 for 3 cycles at byte 20 while crs_dv stays high -> outputs 0 immediately; nothing emitted until crs_dv falls; the following good frame passes.

Source files
------------

// File: rtl/rmii_frame_rx.sv
// RMII receive framer: preamble/SFD detection, dibit-to-byte assembly,
// CRC-32 residue check and per-frame length/error reporting.
module rmii_frame_rx #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crs_dv,
  input  logic        rx_er,
  input  logic [1:0]  rx_d,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        fcs_ok_o,
  output logic        err_o,
  output logic [10:0] frame_len_o
);

  localparam int unsigned LEN_W = 11;
  localparam int unsigned CRC_W = 32;
  localparam int unsigned PRE_W = 4;

  localparam logic [LEN_W-1:0] LEN_SAT     = '1;
  localparam logic [LEN_W-1:0] MIN_LEN_C   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);
  localparam logic [CRC_W-1:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [CRC_W-1:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [PRE_W-1:0] PRE_SAT     = 4'd15;
  localparam logic [PRE_W-1:0] PRE_MIN     = 4'd4;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [5:0]       shift_q, shift_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             err_flag_q, err_flag_d;
  logic             report_q, report_d;
  logic [7:0]       data_d;
  logic             valid_d, sof_d, eof_d, fcs_ok_d, err_d;
  logic [LEN_W-1:0] frame_len_d;
  logic [7:0]       byte_nxt;

  // Reflected CRC-32, one byte LSB first.
  function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc,
                                                  input logic [7:0] b);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign byte_nxt = {rx_d, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DROP;
      pre_cnt_q   <= '0;
      phase_q     <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= CRC_INIT;
      err_flag_q  <= 1'b0;
      report_q    <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
      fcs_ok_o    <= 1'b0;
      err_o       <= 1'b0;
      frame_len_o <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      err_flag_q  <= err_flag_d;
      report_q    <= report_d;
      data_o      <= data_d;
      valid_o     <= valid_d;
      sof_o       <= sof_d;
      eof_o       <= eof_d;
      fcs_ok_o    <= fcs_ok_d;
      err_o       <= err_d;
      frame_len_o <= frame_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    phase_d     = phase_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    err_flag_d  = err_flag_q;
    report_d    = report_q;
    data_d      = data_o;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    fcs_ok_d    = fcs_ok_o;
    err_d       = err_o;
    frame_len_d = frame_len_o;

    case (state_q)
      IDLE: begin
        if (crs_dv && rx_d == 2'b01) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 4'd1;
        end else if (crs_dv && rx_d[1]) begin
          state_d  = DROP;
          report_d = 1'b0;
        end
      end

      PREAMBLE: begin
        if (crs_dv && !rx_er && rx_d == 2'b01) begin
          if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (crs_dv && !rx_er && rx_d == 2'b11 && pre_cnt_q >= PRE_MIN) begin
          state_d    = DATA;
          phase_d    = '0;
          byte_cnt_d = '0;
          crc_d      = CRC_INIT;
          err_flag_d = 1'b0;
        end else begin
          state_d  = DROP;
          report_d = 1'b0;
        end
      end

      // Reporting drop keeps assembling and counting so the length stays exact.
      DATA, DROP: begin
        if (state_q == DROP && !report_q) begin
          if (!crs_dv) state_d = IDLE;
        end else if (!crs_dv) begin
          state_d     = IDLE;
          report_d    = 1'b0;
          eof_d       = 1'b1;
          frame_len_d = byte_cnt_q;
          err_d       = err_flag_q || (phase_q != 2'd0) ||
                        (byte_cnt_q < MIN_LEN_C) || (byte_cnt_q > MAX_LEN_C);
          fcs_ok_d    = (crc_q == CRC_RESIDUE) && (phase_q == 2'd0);
        end else begin
          shift_d = byte_nxt[7:2];
          phase_d = phase_q + 2'd1;
          if (rx_er) err_flag_d = 1'b1;
          if (phase_q == 2'd3) begin
            crc_d = crc_update(crc_q, byte_nxt);
            if (byte_cnt_q != LEN_SAT) byte_cnt_d = byte_cnt_q + 11'd1;
            if (byte_cnt_q >= MAX_LEN_C) begin
              err_flag_d = 1'b1;
              state_d    = DROP;
              report_d   = 1'b1;
            end else if (state_q == DATA) begin
              data_d  = byte_nxt;
              valid_d = 1'b1;
              sof_d   = (byte_cnt_q == '0);
            end
          end
        end
      end

      default: state_d = DROP;
    endcase
  end

endmodule
